// File: rtl/ones_counter_pkg.sv
// Shared types and helpers for the multi-channel ones counter.
// Window-length clamping lives here so every instance handles the 0 and oversize cases the same way.
package ones_counter_pkg;

  typedef enum logic {IDLE, RUN} oc_state_t;
  typedef enum logic {SINGLE, CONT} oc_mode_t;

  // Zero or oversize requests fall back to the longest supported window.
  function automatic int unsigned clamp_len(input int unsigned win_len,
                                            input int unsigned max_samples);
    return (win_len == 0 || win_len > max_samples) ? max_samples : win_len;
  endfunction

endpackage

// File: rtl/ones_acc_ch.sv
// Single-channel ones accumulator: clear, add one sample per cycle, and
// capture acc+current sample into the result register at window end.
module ones_acc_ch #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add_en,
  input  logic          cap,
  input  logic          bit_in,
  output logic [CW-1:0] result
);

  logic [CW-1:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      // The window-end sample goes straight into the result, not into acc.
      if (clr || cap)  acc <= '0;
      else if (add_en) acc <= acc + CW'(bit_in);
      if (cap) result <= acc + CW'(bit_in);
    end
  end

endmodule

// File: rtl/ones_counter_mc.sv
// Multi-channel sigma-delta ones counter: FSM, shared sample counter and
// result handshake with sticky overrun; per-channel counting in ones_acc_ch.
module ones_counter_mc
  import ones_counter_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int MAX_SAMPLES = 2047,
  localparam int CW          = $clog2(MAX_SAMPLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CW-1:0]      win_len,
  input  logic [N_CH-1:0]    pulse,
  output logic [N_CH*CW-1:0] ones,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun
);

  oc_state_t               state_q, state_d;
  oc_mode_t                mode_q;
  logic [CW-1:0]           len_q, sample_cnt;
  logic                    accept, win_end, clr;
  logic [N_CH-1:0][CW-1:0] res;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop)                          state_d = IDLE;
        else if (win_end && mode_q == SINGLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // stop wins over the window-end capture, so an aborted last sample yields nothing.
  always_comb begin
    busy    = (state_q == RUN);
    accept  = (state_q == IDLE) && start && !stop;
    win_end = (state_q == RUN) && !stop && (sample_cnt == len_q - CW'(1));
    clr     = accept || ((state_q == RUN) && stop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      mode_q     <= SINGLE;
      sample_cnt <= '0;
    end else if (accept) begin
      len_q      <= CW'(clamp_len(32'(win_len), MAX_SAMPLES));
      mode_q     <= oc_mode_t'(mode);
      sample_cnt <= '0;
    end else if (state_q == RUN) begin
      if (stop || win_end) sample_cnt <= '0;
      else                 sample_cnt <= sample_cnt + CW'(1);
    end
  end

  // A load on the same edge as a transfer replaces the result without overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) overrun <= 1'b0;
      if (win_end) begin
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ones_acc_ch #(.CW(CW)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .add_en (busy),
      .cap    (win_end),
      .bit_in (pulse[i]),
      .result (res[i])
    );
  end

  assign ones = res;

endmodule
